// File: rtl/lap_stopwatch.sv
// lap_stopwatch: min/sec/centisecond stopwatch with run/pause/idle control, clear and a lap buffer
module lap_stopwatch #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 59,
  parameter int LAP_DEPTH = 8,
  localparam int MIN_W = $clog2(MAX_MIN + 1),
  localparam int PTR_W = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             record,
  input  logic             clear,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [MIN_W-1:0] min_o,
  output logic [5:0]       sec_o,
  output logic [6:0]       ms_10_o,
  output logic             running_o,
  output logic             ovf_o,
  output logic [PTR_W-1:0] lap_cnt_o,
  output logic             full_o,
  output logic             lap_drop_o,
  output logic             lap_valid_o,
  output logic [MIN_W-1:0] lap_min_o,
  output logic [5:0]       lap_sec_o,
  output logic [6:0]       lap_ms_10_o
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int AW = LAP_DEPTH > 1 ? $clog2(LAP_DEPTH) : 1;
  localparam int LW = MIN_W + 13;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t           state;
  logic [DIV_W-1:0] div;
  logic [LW-1:0]    mem [LAP_DEPTH];
  logic [LW-1:0]    now_t;
  logic [PTR_W-1:0] cnt_nxt;
  logic             tick, at_max, wr, go_idle;
  assign now_t     = {min_o, sec_o, ms_10_o};
  assign running_o = state == RUN;
  assign full_o    = lap_cnt_o == PTR_W'(LAP_DEPTH);
  assign tick      = running_o && div == DIV_W'(DIV - 1);
  assign at_max    = min_o == MIN_W'(MAX_MIN) && sec_o == 6'd59 && ms_10_o == 7'd99;
  assign go_idle   = state == PAUSE && clear;
  assign wr        = running_o && record && !full_o;
  assign cnt_nxt   = go_idle ? '0 : lap_cnt_o + PTR_W'(wr);
  // Lap storage has no reset; entries at or above lap_cnt_o are masked on read.
  always_ff @(posedge clk)
    if (wr) mem[lap_cnt_o[AW-1:0]] <= now_t;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      div <= '0;
      min_o <= '0;
      sec_o <= '0;
      ms_10_o <= '0;
      ovf_o <= 1'b0;
      lap_cnt_o <= '0;
      lap_drop_o <= 1'b0;
      lap_valid_o <= 1'b0;
      {lap_min_o, lap_sec_o, lap_ms_10_o} <= '0;
    end else begin
      state <= go_idle ? IDLE : pause ? (state == RUN ? PAUSE : RUN) : state;
      lap_drop_o <= running_o && record && full_o;
      lap_cnt_o <= cnt_nxt;
      // Read path looks at the post-write buffer so a same-cycle write is forwarded.
      lap_valid_o <= rd_idx < cnt_nxt;
      {lap_min_o, lap_sec_o, lap_ms_10_o} <= rd_idx >= cnt_nxt ? '0 :
        (wr && rd_idx == lap_cnt_o) ? now_t : mem[rd_idx[AW-1:0]];
      if (go_idle) begin
        div <= '0;
        min_o <= '0;
        sec_o <= '0;
        ms_10_o <= '0;
        ovf_o <= 1'b0;
      end else if (running_o) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick && !ovf_o) begin
          if (at_max) ovf_o <= 1'b1;
          else begin
            ms_10_o <= ms_10_o == 7'd99 ? '0 : ms_10_o + 7'd1;
            if (ms_10_o == 7'd99) begin
              sec_o <= sec_o == 6'd59 ? '0 : sec_o + 6'd1;
              if (sec_o == 6'd59) min_o <= min_o + 1'b1;
            end
          end
        end
      end
    end
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised successor to the team's stopwatch counter.
- Keeps the min/sec/10 ms display counter and adds a configurable tick divider, a run/pause/idle state machine, a clear command and a lap-record buffer of depth LAP_DEPTH.
- Sits between the debounced button-pulse logic and the display/lap-browse mux.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- TICK_HZ, 100, centisecond tick rate. DIV = CLK_FREQ_HZ/TICK_HZ; DIV must be >= 2.
- MAX_MIN, 59, largest minute value. MIN_W = clog2(MAX_MIN+1).
- LAP_DEPTH, 8, number of lap entries. PTR_W = clog2(LAP_DEPTH+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pause  in  1  single-cycle pulse: start/pause toggle
- record  in  1  single-cycle pulse: store the current time as a lap
- clear  in  1  single-cycle pulse: return to zero, empty the lap buffer
- rd_idx  in  PTR_W  lap entry to read, 0 = oldest
- min_o  out  MIN_W  live minutes
- sec_o  out  6  live seconds
- ms_10_o  out  7  live centiseconds
- running_o  out  1  high in RUN
- ovf_o  out  1  sticky: saturated at MAX_MIN:59:99
- lap_cnt_o  out  PTR_W  number of stored laps
- full_o  out  1  lap_cnt_o == LAP_DEPTH
- lap_drop_o  out  1  one-cycle pulse: a record was rejected because the buffer was full
- lap_valid_o  out  1  rd_idx < lap_cnt_o (registered)
- lap_min_o / lap_sec_o / lap_ms_10_o  out  MIN_W/6/7  lap entry at rd_idx (registered)

Behaviour:
- Reset (rst=0, async): state IDLE, divider 0, all outputs 0. lap_valid_o=0, and the lap data outputs are 0.
- All logic is synchronous to the rising edge of clk. Input pulses are already synchronous and debounced upstream.

State machine:
- IDLE --pause--> RUN.
- RUN --pause--> PAUSE.
- PAUSE --pause--> RUN.
- PAUSE --clear--> IDLE.
- clear is ignored in RUN and IDLE.
- In PAUSE with clear and pause in the same cycle, clear wins: next state is IDLE.
- Entering IDLE zeroes the time, the divider, ovf_o, lap_cnt_o and full_o.

Divider:
- Counts 0..DIV-1 only in RUN and holds its value in PAUSE, so a resumed run keeps its sub-tick phase.
- Tick = (div == DIV-1) in RUN. The divider wraps to 0 on the tick.

Time counter, on tick:
- ms_10 increments, wrapping 99→0 and carrying into sec.
- sec wraps 59→0 and carries into min.
- The display updates in the cycle after the tick edge (1-cycle latency from tick to output).

Saturation:
- A tick while the time is MAX_MIN:59:99 leaves the time unchanged and sets ovf_o.
- State stays RUN.
- Once ovf_o=1, all further ticks are ignored until IDLE.

Record:
- Acted on only in RUN. In IDLE or PAUSE, record is ignored.
- Stores the register values present in that cycle, i.e. the pre-increment value if a tick coincides. Writes to entry lap_cnt_o, then lap_cnt_o increments.
- When lap_cnt_o == LAP_DEPTH, no write occurs and lap_drop_o=1 for one cycle.
- record and pause in the same RUN cycle: the lap is stored and the state goes to PAUSE.

Read:
- lap_* outputs and lap_valid_o are registered from rd_idx, with 1-cycle latency.
- rd_idx >= lap_cnt_o gives lap_valid_o=0 and lap data = 0.
- A read of the entry being written in the same cycle returns the new data one cycle later.

Storage: the lap buffer may be registers or distributed RAM. Entries at or above lap_cnt_o are never visible.

Reset mid-run: asynchronous return to the reset state; the buffer contents become invisible because lap_cnt_o=0.

Test Plan:
1. Override CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10). Release rst, pulse pause → running_o=1; after 1000 clk, time = 0:01:00.
2. Run to 0:00:57, pulse pause, wait 50 clk, pulse pause → time still 0:00:57 during the wait; next tick arrives after the remaining divider count, not a full 10.
3. LAP_DEPTH=4: pulse record at 0:00:10, 0:00:20, 0:00:30, 0:00:40, 0:00:50 → lap_cnt_o=4, full_o=1, lap_drop_o pulses on the 5th; rd_idx=3 gives 0:00:40 one cycle later; rd_idx=4 gives lap_valid_o=0.
4. MAX_MIN=1: run to 1:59:99, apply 5 more ticks → time holds 1:59:99, ovf_o=1; pause then clear → IDLE, all zero, ovf_o=0.
5. Simultaneous cases: record+tick in the same cycle stores the pre-increment value; record+pause in RUN stores the lap and enters PAUSE; clear+pause in PAUSE → IDLE; clear in RUN → ignored.
6. Assert rst low asynchronously mid-count (between edges) → outputs 0 immediately; after release, pause restarts from 0:00:00 with lap_cnt_o=0.
